// File: rtl/jt12_pkg.sv
// Shared constants for the FM operator-state RAM: the clear-FSM encoding and
// the default word/address sizes of an operator slot-state bundle.
package jt12_pkg;
   localparam int OP_DW = 44;
   localparam int OP_AW = 5;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;
endpackage

// File: rtl/jt12_opram_clr_if.sv
// User port of the operator-state RAM: write/read addresses, data and clear
// request in, registered read data and clear-busy flag out.
interface jt12_opram_clr_if
   import jt12_pkg::*;
#(
   parameter int DW = OP_DW,
   parameter int AW = OP_AW
);
   logic          clr;
   logic          we;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] data;
   logic [DW-1:0] q;
   logic          busy;

   modport master (output clr, we, wr_addr, rd_addr, data, input q, busy);
   modport slave  (input clr, we, wr_addr, rd_addr, data, output q, busy);
endinterface

// File: rtl/jt12_dpram_core.sv
// 1R/1W storage array with registered read port; same-address read-during-write
// returns either the stored word or, when RDW_NEW is set, the incoming data.
module jt12_dpram_core #(
   parameter int DW      = 44,
   parameter int AW      = 5,
   parameter int RDW_NEW = 0
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          cen,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] data,
   input  logic          q_zero,
   output logic [DW-1:0] q
);
   logic [DW-1:0] mem [0:(2**AW)-1];
   logic          bypass;

   // Bypass is an explicit compare so the policy never depends on the RAM macro.
   assign bypass = (RDW_NEW != 0) && we && (wr_addr == rd_addr);

   always_ff @(posedge clk) begin
      if (cen && we) mem[wr_addr] <= data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          q <= '0;
      else if (cen) begin
         if (q_zero)      q <= '0;
         else if (bypass) q <= data;
         else             q <= mem[rd_addr];
      end
   end
endmodule

// File: rtl/jt12_opram_clr.sv
// Operator-state RAM with a zero-fill sequencer that owns the write port while
// clearing, so the core restarts from known state on any reset or clr request.
module jt12_opram_clr
   import jt12_pkg::*;
#(
   parameter int DW       = OP_DW,
   parameter int AW       = OP_AW,
   parameter int RDW_NEW  = 0,
   parameter int INIT_CLR = 1
) (
   input  logic rst,
   input  logic clk,
   input  logic clk_en,
   jt12_opram_clr_if.slave bus
);
   localparam logic [0:0] ST_RST   = (INIT_CLR != 0) ? ST_CLEAR : ST_IDLE;
   localparam logic       BUSY_RST = (INIT_CLR != 0);

   logic [0:0]    state;
   logic [AW-1:0] cnt;
   logic          busy;
   logic          in_clr;
   logic          mem_we;
   logic [AW-1:0] mem_wa;
   logic [DW-1:0] mem_d;

   assign in_clr = (state == ST_CLEAR);

   // Clearing steals the write port; user writes are dropped, not queued.
   always_comb begin
      mem_we = bus.we;
      mem_wa = bus.wr_addr;
      mem_d  = bus.data;
      if (in_clr) begin
         mem_we = 1'b1;
         mem_wa = cnt;
         mem_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RST;
         cnt   <= '0;
         busy  <= BUSY_RST;
      end else if (clk_en) begin
         case (state)
            ST_IDLE: if (bus.clr) begin
               state <= ST_CLEAR;
               cnt   <= '0;
               busy  <= 1'b1;
            end
            ST_CLEAR: begin
               cnt <= cnt + AW'(1);
               if (&cnt) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy;

   jt12_dpram_core #(.DW(DW), .AW(AW), .RDW_NEW(RDW_NEW)) u_core (
      .rst     (rst),
      .clk     (clk),
      .cen     (clk_en),
      .we      (mem_we),
      .wr_addr (mem_wa),
      .rd_addr (bus.rd_addr),
      .data    (mem_d),
      .q_zero  (in_clr),
      .q       (bus.q)
   );
endmodule

// File: tb/tb_jt12_opram_clr.sv
// Directed bench: three instances share stimulus (old-data RDW, new-data RDW,
// and one that comes out of reset idle) and are compared to hand-computed values.
module tb_jt12_opram_clr;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b1;
   logic        clr = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [4:0]  rd_addr = '0;
   logic [43:0] data = '0;

   int n_chk = 0;
   int n_err = 0;

   jt12_opram_clr_if #(.DW(44), .AW(5)) ia ();
   jt12_opram_clr_if #(.DW(44), .AW(5)) ib ();
   jt12_opram_clr_if #(.DW(44), .AW(5)) ic ();

   assign ia.clr = clr;  assign ia.we = we;  assign ia.wr_addr = wr_addr;
   assign ia.rd_addr = rd_addr;  assign ia.data = data;
   assign ib.clr = clr;  assign ib.we = we;  assign ib.wr_addr = wr_addr;
   assign ib.rd_addr = rd_addr;  assign ib.data = data;
   assign ic.clr = clr;  assign ic.we = we;  assign ic.wr_addr = wr_addr;
   assign ic.rd_addr = rd_addr;  assign ic.data = data;

   jt12_opram_clr #(.DW(44), .AW(5), .RDW_NEW(0), .INIT_CLR(1)) dut_a (
      .rst(rst), .clk(clk), .clk_en(clk_en), .bus(ia));
   jt12_opram_clr #(.DW(44), .AW(5), .RDW_NEW(1), .INIT_CLR(1)) dut_b (
      .rst(rst), .clk(clk), .clk_en(clk_en), .bus(ib));
   jt12_opram_clr #(.DW(44), .AW(5), .RDW_NEW(0), .INIT_CLR(0)) dut_c (
      .rst(rst), .clk(clk), .clk_en(clk_en), .bus(ic));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n, bad, clocks, en;
      logic [43:0] prevq;

      // reset state
      step(); step();
      chk("rst_busy_a", 64'(ia.busy), 64'd1);
      chk("rst_q_a", 64'(ia.q), 64'd0);
      chk("rst_busy_c", 64'(ic.busy), 64'd0);
      chk("rst_q_c", 64'(ic.q), 64'd0);

      // power-on clear: 32 enabled edges, q stays 0
      rst = 1'b0;
      n = 0; bad = 0;
      while (ia.busy && n < 40) begin
         step(); n++;
         if (ia.q !== 44'd0 || ib.q !== 44'd0) bad++;
      end
      chk("init_clr_edges", 64'(n), 64'd32);
      chk("init_clr_q", 64'(bad), 64'd0);
      chk("init_busy_b", 64'(ib.busy), 64'd0);
      bad = 0;
      for (int k = 0; k < 32; k++) begin
         rd_addr = 5'(k); step();
         if (ia.q !== 44'd0 || ib.q !== 44'd0) bad++;
      end
      chk("init_read_zero", 64'(bad), 64'd0);

      // idle write then read
      we = 1'b1; wr_addr = 5'd5; data = 44'h123_4567_89AB; step();
      we = 1'b0; rd_addr = 5'd5; step();
      chk("wr_rd_a", 64'(ia.q), 64'h123_4567_89AB);
      chk("wr_rd_b", 64'(ib.q), 64'h123_4567_89AB);
      rd_addr = 5'd6; step();
      chk("rd_addr6", 64'(ia.q), 64'd0);

      // same-address read-during-write
      we = 1'b1; wr_addr = 5'd3; data = 44'hAAA; step();
      data = 44'hBBB; rd_addr = 5'd3; step();
      chk("rdw_old_a", 64'(ia.q), 64'hAAA);
      chk("rdw_new_b", 64'(ib.q), 64'hBBB);
      we = 1'b0; step();
      chk("rdw_after_a", 64'(ia.q), 64'hBBB);
      chk("rdw_after_b", 64'(ib.q), 64'hBBB);

      // disabled edges: no write, q holds
      clk_en = 1'b0; we = 1'b1; wr_addr = 5'd3; data = 44'hCCC; rd_addr = 5'd5;
      step(); step(); step();
      chk("frz_q", 64'(ia.q), 64'hBBB);
      chk("frz_busy", 64'(ia.busy), 64'd0);
      clk_en = 1'b1; we = 1'b0; rd_addr = 5'd3; step();
      chk("frz_mem_a", 64'(ia.q), 64'hBBB);
      chk("frz_mem_b", 64'(ib.q), 64'hBBB);

      // clear with clk_en 1-in-6
      clr = 1'b1; step(); clr = 1'b0;
      clocks = 0; en = 0; bad = 0; prevq = ia.q;
      while (ia.busy && clocks < 400) begin
         clk_en = ((clocks + 1) % 6 == 0);
         step(); clocks++;
         if (clk_en) en++;
         else if (ia.q !== prevq || ia.busy !== 1'b1) bad++;
         prevq = ia.q;
      end
      clk_en = 1'b1;
      chk("gate_clocks", 64'(clocks), 64'd192);
      chk("gate_en_edges", 64'(en), 64'd32);
      chk("gate_frozen", 64'(bad), 64'd0);
      rd_addr = 5'd5; step();
      chk("gate_rd5", 64'(ia.q), 64'd0);

      // fill with index, clear with writes attempted and a second clr at count 10
      we = 1'b1;
      for (int k = 0; k < 32; k++) begin
         wr_addr = 5'(k); data = 44'(k); step();
      end
      we = 1'b0; rd_addr = 5'd9; step();
      chk("fill_rd9", 64'(ia.q), 64'd9);
      clr = 1'b1; we = 1'b1; data = 44'hFFF; wr_addr = 5'd0; step();
      n = 0;
      while (ia.busy && n < 40) begin
         clr = (n == 10);
         wr_addr = 5'(n);
         step(); n++;
      end
      clr = 1'b0; we = 1'b0;
      chk("midclr_edges", 64'(n), 64'd32);
      bad = 0;
      for (int k = 0; k < 32; k++) begin
         rd_addr = 5'(k); step();
         if (ia.q !== 44'd0 || ib.q !== 44'd0) bad++;
      end
      chk("midclr_zero", 64'(bad), 64'd0);

      // async reset in idle with q non-zero
      we = 1'b1; wr_addr = 5'd1; data = 44'h77; step();
      we = 1'b0; rd_addr = 5'd1; step();
      chk("pre_rst_q", 64'(ia.q), 64'h77);
      #3 rst = 1'b1;
      #1;
      chk("arst_q_a", 64'(ia.q), 64'd0);
      chk("arst_busy_a", 64'(ia.busy), 64'd1);
      chk("arst_busy_c", 64'(ic.busy), 64'd0);
      rst = 1'b0;

      // async reset at count 17 of the restart clear
      for (int k = 0; k < 17; k++) step();
      chk("cnt17_busy", 64'(ia.busy), 64'd1);
      #3 rst = 1'b1;
      #1;
      chk("arst17_q_a", 64'(ia.q), 64'd0);
      chk("arst17_busy_b", 64'(ib.busy), 64'd1);
      chk("arst17_busy_c", 64'(ic.busy), 64'd0);
      rst = 1'b0;
      n = 0;
      while (ia.busy && n < 40) begin
         step(); n++;
      end
      chk("arst_restart_edges", 64'(n), 64'd32);
      rd_addr = 5'd1; step();
      chk("arst_rd1", 64'(ia.q), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
